// File: rtl/pwm_pkg.sv
// Shared PWM definitions: code widths, legal periods, measurement FSM states, result record.
// Latency: none (types and constants only).
// Backpressure: none.
package pwm_pkg;

  localparam int DUTY_W = 4;
  localparam int FREQ_W = 2;

  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(10);

  // Period in clock cycles for frequency codes 0..3.
  localparam int PER_F0 = 80;
  localparam int PER_F1 = 40;
  localparam int PER_F2 = 20;
  localparam int PER_F3 = 10;

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_MEAS   = 2'd1,
    ST_STATIC = 2'd2
  } meas_st_e;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [FREQ_W-1:0] freq;
    logic              valid;
    logic              stat;
    logic              err;
  } meas_res_t;

  // Clamp a scaled high-time to the largest legal duty code.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [31:0] v);
    if (v > 32'(DUTY_MAX)) return DUTY_MAX;
    return v[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_meas_if.sv
// Result bundle of the PWM measurement block (duty/freq codes and status flags).
// Latency: none (wires only).
// Backpressure: none; o_upd is a one-cycle strobe with no ready.
interface pwm_meas_if;

  logic [pwm_pkg::DUTY_W-1:0] o_duty;
  logic [pwm_pkg::FREQ_W-1:0] o_freq;
  logic                       o_valid;
  logic                       o_static;
  logic                       o_upd;
  logic                       o_err;

  modport master (output o_duty, o_freq, o_valid, o_static, o_upd, o_err);
  modport slave  (input  o_duty, o_freq, o_valid, o_static, o_upd, o_err);

endinterface

// File: rtl/pwm_edge_sync.sv
// Synchronises the PWM pin, optionally majority-filters it (PWM_MEAS_GLITCH_FILTER_EN), flags rises.
// Latency: rise/level valid 2 cycles after the pin changes, 3 with the filter built in.
// Backpressure: none.
module pwm_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic level;

`ifdef PWM_MEAS_GLITCH_FILTER_EN
  logic h1_q, h1_d;
  logic h2_q, h2_d;

  // 3-sample majority: a level must persist 2 cycles to pass, so 1-cycle pulses vanish
  always_comb begin
    h1_d  = s2_q;
    h2_d  = h1_q;
    level = (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
  end

  // filter history
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else begin
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end
`else
  // unfiltered: the synchroniser output is the measured level
  always_comb level = s2_q;
`endif

  // synchroniser chain and previous-level register for edge detect
  always_comb begin
    s1_d   = i_pwm;
    s2_d   = s1_q;
    prev_d = level;
  end

  // synchroniser and edge-detect flops
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = level;
  assign o_rise  = level & ~prev_q;

endmodule

// File: rtl/pwm_meas.sv
// Recovers duty/frequency codes from a PWM line; glitch filter under PWM_MEAS_GLITCH_FILTER_EN.
// Latency: results registered 1 cycle after the rise detect (3-4 cycles after the pin edge).
// Backpressure: none; each result is announced by a single o_upd strobe.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 160
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pwm,
  pwm_meas_if.master mif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

  logic level, rise;

  pwm_edge_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_pwm   (i_pwm),
    .o_level (level),
    .o_rise  (rise)
  );

  meas_st_e          state_q, state_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [CNT_W-1:0]  high_q, high_d;
  meas_res_t         res_q, res_d;
  logic              upd_q, upd_d;

  logic              timeout;
  logic              legal;
  logic [FREQ_W-1:0] freq_c;
  logic [DUTY_W-1:0] duty_c;

  // per_q doubles as "cycles since last rise", so it also drives the static timeout
  assign timeout = (per_q >= TO_LIM);

  // map the closed period onto a frequency code and scale H back to duty tenths
  always_comb begin
    legal  = 1'b1;
    freq_c = '0;
    duty_c = '0;
    if (per_q == CNT_W'(PER_F0)) begin
      freq_c = FREQ_W'(0);
      duty_c = sat_duty(32'(high_q >> 3));
    end else if (per_q == CNT_W'(PER_F1)) begin
      freq_c = FREQ_W'(1);
      duty_c = sat_duty(32'(high_q >> 2));
    end else if (per_q == CNT_W'(PER_F2)) begin
      freq_c = FREQ_W'(2);
      duty_c = sat_duty(32'(high_q >> 1));
    end else if (per_q == CNT_W'(PER_F3)) begin
      freq_c = FREQ_W'(3);
      duty_c = sat_duty(32'(high_q));
    end else begin
      legal = 1'b0;
    end
  end

  // period and high-time counters: restart at each rise (the rise cycle is already high), saturate
  always_comb begin
    per_d  = (per_q == CNT_MAX) ? per_q : per_q + ONE;
    high_d = (level && (high_q != CNT_MAX)) ? high_q + ONE : high_q;
    if (rise) begin
      per_d  = ONE;
      high_d = ONE;
    end
  end

  // measurement FSM; a rise always wins over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    upd_d   = 1'b0;
    case (state_q)
      ST_ACQ: begin
        if (rise) begin
          state_d = ST_MEAS;
        end else if (timeout) begin
          state_d    = ST_STATIC;
          res_d.duty = level ? DUTY_MAX : '0;
          res_d.stat = 1'b1;
          res_d.valid = 1'b1;
          upd_d      = 1'b1;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          upd_d = 1'b1;
          if (legal) begin
            res_d.duty  = duty_c;
            res_d.freq  = freq_c;
            res_d.valid = 1'b1;
            res_d.err   = 1'b0;
          end else begin
            res_d.err = 1'b1;
          end
        end else if (timeout) begin
          state_d     = ST_STATIC;
          res_d.duty  = level ? DUTY_MAX : '0;
          res_d.stat  = 1'b1;
          res_d.valid = 1'b1;
          upd_d       = 1'b1;
        end
      end
      ST_STATIC: begin
        // leaving static rewrites o_static, so it is announced like any other write
        if (rise) begin
          state_d    = ST_ACQ;
          res_d.stat = 1'b0;
          upd_d      = 1'b1;
        end
      end
      default: state_d = ST_ACQ;
    endcase
  end

  // state, counters and registered results
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_ACQ;
      per_q   <= '0;
      high_q  <= '0;
      res_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      high_q  <= high_d;
      res_q   <= res_d;
      upd_q   <= upd_d;
    end
  end

  assign mif.o_duty   = res_q.duty;
  assign mif.o_freq   = res_q.freq;
  assign mif.o_valid  = res_q.valid;
  assign mif.o_static = res_q.stat;
  assign mif.o_err    = res_q.err;
  assign mif.o_upd    = upd_q;

endmodule
